// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
package fetch_unit_pkg;

  // Bytes per op word, and the width of the byte index within a word.
  localparam int FETCH_BYTES = 4;
  localparam int IDX_W       = $clog2(FETCH_BYTES);

  // Byte-lane order of the assembled word. The lowest address lands in [7:0].
  typedef enum logic {
    LANE_LITTLE = 1'b0,
    LANE_BIG    = 1'b1
  } lane_order_e;

  localparam lane_order_e LANE_ORDER = LANE_LITTLE;

  // Default first fetch address after reset. Must be word-aligned.
  localparam int unsigned RESET_PC_DEFAULT = 0;

  // Bit position of byte lane idx inside the 32-bit op word.
  function automatic int lane_lsb(input logic [IDX_W-1:0] idx);
    if (LANE_ORDER == LANE_LITTLE) return 8 * int'(idx);
    else                           return 8 * (FETCH_BYTES - 1 - int'(idx));
  endfunction

endpackage

// File: rtl/fetch_word_buffer.sv
// Two-entry op word buffer: one presented word plus one prefetched word.
module fetch_word_buffer
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  take,
  input  logic                  push,
  input  logic [31:0]           push_word,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  output logic [31:0]           word,
  output logic [ADDR_WIDTH-1:0] word_pc,
  output logic                  valid,
  output logic                  hold_full
);

  logic [31:0]           out_reg;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  out_valid;
  logic [31:0]           hold_reg;
  logic [ADDR_WIDTH-1:0] hold_pc;
  logic                  hold_vld;
  logic                  take_ok;

  // A take only counts while a word is actually presented.
  assign take_ok = take && out_valid;

  // Output/hold update. Flush wins; a take refills from hold first, then from
  // a word completing this cycle. The producer never pushes while hold is full
  // unless the same cycle also drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      out_pc    <= '0;
      out_valid <= 1'b0;
      hold_reg  <= '0;
      hold_pc   <= '0;
      hold_vld  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      hold_vld  <= 1'b0;
    end else if (take_ok) begin
      if (hold_vld) begin
        out_reg   <= hold_reg;
        out_pc    <= hold_pc;
        out_valid <= 1'b1;
        if (push) begin
          hold_reg <= push_word;
          hold_pc  <= push_pc;
        end else begin
          hold_vld <= 1'b0;
        end
      end else if (push) begin
        out_reg   <= push_word;
        out_pc    <= push_pc;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid) begin
        out_reg   <= push_word;
        out_pc    <= push_pc;
        out_valid <= 1'b1;
      end else begin
        hold_reg <= push_word;
        hold_pc  <= push_pc;
        hold_vld <= 1'b1;
      end
    end
  end

  assign word      = out_reg;
  assign word_pc   = out_pc;
  assign valid     = out_valid;
  assign hold_full = hold_vld;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads byte-wide program memory, assembles 32-bit
// little-endian op words and presents them through a valid/take handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 17,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  CLK,
  input  logic                  N_RST,
  input  logic                  N_BOOTED,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_N_OE,
  input  logic [7:0]            MEM_DATA,
  output logic [31:0]           OP_WORD,
  output logic [ADDR_WIDTH-1:0] OP_PC,
  output logic                  OP_VALID,
  input  logic                  OP_TAKE,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [IDX_W-1:0]      idx;
  logic [23:0]           asm_reg;
  logic                  hold_full;
  logic                  fetch;
  logic                  word_done;
  logic [31:0]           word_next;
  logic [ADDR_WIDTH-1:0] jump_pc;

  // Reset is folded in so the bus is released the moment N_RST falls,
  // without waiting for the registers to settle.
  assign fetch     = N_RST && !N_BOOTED && !hold_full && !JUMP;
  assign word_done = fetch && (idx == IDX_W'(FETCH_BYTES - 1));
  assign MEM_N_OE  = !fetch;
  assign MEM_ADDR  = pc + ADDR_WIDTH'(idx);
  assign jump_pc   = {JUMP_ADDR[ADDR_WIDTH-1:2], 2'b00};

  // Partial word with the current memory byte merged into its lane. At the
  // last byte this is the finished word; earlier, its low lanes feed asm_reg.
  always_comb begin
    word_next = {8'h00, asm_reg};
    word_next[lane_lsb(idx) +: 8] = MEM_DATA;
  end

  // Byte counter and word address. Jump overrides everything; a pause
  // (boot not done or hold full) leaves idx and asm_reg untouched.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      pc      <= RESET_PC;
      idx     <= '0;
      asm_reg <= '0;
    end else if (JUMP) begin
      pc  <= jump_pc;
      idx <= '0;
    end else if (fetch) begin
      if (word_done) begin
        pc  <= pc + ADDR_WIDTH'(FETCH_BYTES);
        idx <= '0;
      end else begin
        asm_reg <= word_next[23:0];
        idx     <= idx + 1'b1;
      end
    end
  end

  fetch_word_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (N_RST),
    .flush     (JUMP),
    .take      (OP_TAKE),
    .push      (word_done),
    .push_word (word_next),
    .push_pc   (pc),
    .word      (OP_WORD),
    .word_pc   (OP_PC),
    .valid     (OP_VALID),
    .hold_full (hold_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte-wide memory model.
module tb_fetch_unit;

  localparam int AW = 17;

  logic          CLK;
  logic          N_RST;
  logic          N_BOOTED;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_N_OE;
  logic [7:0]    MEM_DATA;
  logic [31:0]   OP_WORD;
  logic [AW-1:0] OP_PC;
  logic          OP_VALID;
  logic          OP_TAKE;
  logic          JUMP;
  logic [AW-1:0] JUMP_ADDR;

  logic [7:0] mem [0:(1<<AW)-1];
  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int rd_base;

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .CLK       (CLK),
    .N_RST     (N_RST),
    .N_BOOTED  (N_BOOTED),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_N_OE  (MEM_N_OE),
    .MEM_DATA  (MEM_DATA),
    .OP_WORD   (OP_WORD),
    .OP_PC     (OP_PC),
    .OP_VALID  (OP_VALID),
    .OP_TAKE   (OP_TAKE),
    .JUMP      (JUMP),
    .JUMP_ADDR (JUMP_ADDR)
  );

  assign MEM_DATA = mem[MEM_ADDR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count memory reads: cycles with the output enable asserted.
  always @(posedge CLK) if (!MEM_N_OE) rd_cnt <= rd_cnt + 1;

  // Hard bound on the whole run.
  initial begin
    #20000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    for (int a = 0; a < (1<<AW); a++) mem[a] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    mem[8] = 8'h99; mem[9] = 8'hAA; mem[10] = 8'hBB; mem[11] = 8'hCC;
    mem['h100] = 8'hA0; mem['h101] = 8'hA1; mem['h102] = 8'hA2; mem['h103] = 8'hA3;
    mem['h104] = 8'hB0; mem['h105] = 8'hB1; mem['h106] = 8'hB2; mem['h107] = 8'hB3;
    mem['h1FFFC] = 8'hF1; mem['h1FFFD] = 8'hF2; mem['h1FFFE] = 8'hF3; mem['h1FFFF] = 8'hF4;

    N_RST = 1'b1; N_BOOTED = 1'b1; OP_TAKE = 1'b0; JUMP = 1'b0; JUMP_ADDR = '0;
    #1 N_RST = 1'b0;
    #1;
    check("rst_valid", 32'(OP_VALID), 32'h0);
    check("rst_word",  OP_WORD,       32'h0);
    check("rst_pc",    32'(OP_PC),    32'h0);
    check("rst_noe",   32'(MEM_N_OE), 32'h1);
    check("rst_addr",  32'(MEM_ADDR), 32'h0);
    tick(2);

    // Cold start: cycle 0 begins here.
    rd_base = rd_cnt;
    N_RST = 1'b1; N_BOOTED = 1'b0;
    #1;
    check("c0_noe",  32'(MEM_N_OE), 32'h0);
    check("c0_addr", 32'(MEM_ADDR), 32'h0);
    tick();
    check("c1_addr", 32'(MEM_ADDR), 32'h1);
    check("c1_valid", 32'(OP_VALID), 32'h0);
    tick(2);
    check("c3_addr", 32'(MEM_ADDR), 32'h3);
    check("c3_valid", 32'(OP_VALID), 32'h0);
    tick();
    check("c4_valid", 32'(OP_VALID), 32'h1);
    check("c4_word",  OP_WORD,       32'h44332211);
    check("c4_pc",    32'(OP_PC),    32'h0);

    // Consumer stall: one word out, one in hold, then the bus goes idle.
    tick(20);
    check("stall_reads", 32'(rd_cnt - rd_base), 32'd8);
    check("stall_noe",   32'(MEM_N_OE), 32'h1);
    check("stall_pc",    32'(OP_PC),    32'h0);
    check("stall_valid", 32'(OP_VALID), 32'h1);

    // Take with hold full: zero bubble, fetch resumes immediately.
    OP_TAKE = 1'b1;
    tick();
    OP_TAKE = 1'b0;
    #1;
    check("take_valid", 32'(OP_VALID), 32'h1);
    check("take_pc",    32'(OP_PC),    32'h4);
    check("take_word",  OP_WORD,       32'h88776655);
    check("take_noe",   32'(MEM_N_OE), 32'h0);
    check("take_addr",  32'(MEM_ADDR), 32'h8);

    // Jump mid-word at idx=2 to an unaligned target.
    tick(2);
    check("pre_jump_addr", 32'(MEM_ADDR), 32'hA);
    JUMP = 1'b1; JUMP_ADDR = 17'h103;
    #1;
    check("jump_noe", 32'(MEM_N_OE), 32'h1);
    tick();
    JUMP = 1'b0;
    #1;
    check("jump_k1_valid", 32'(OP_VALID), 32'h0);
    check("jump_k1_addr",  32'(MEM_ADDR), 32'h100);
    check("jump_k1_noe",   32'(MEM_N_OE), 32'h0);
    tick(4);
    check("jump_k5_valid", 32'(OP_VALID), 32'h1);
    check("jump_k5_pc",    32'(OP_PC),    32'h100);
    check("jump_k5_word",  OP_WORD,       32'hA3A2A1A0);

    // Boot pause at idx=1: bus released, resume at the same byte.
    tick();
    check("pause_addr", 32'(MEM_ADDR), 32'h105);
    N_BOOTED = 1'b1;
    rd_base = rd_cnt;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("pause_noe", 32'(MEM_N_OE), 32'h1);
      tick();
    end
    check("pause_reads", 32'(rd_cnt - rd_base), 32'd0);
    check("pause_hold_addr", 32'(MEM_ADDR), 32'h105);
    N_BOOTED = 1'b0;
    #1;
    check("resume_noe", 32'(MEM_N_OE), 32'h0);
    tick(3);
    check("resume_idle", 32'(MEM_N_OE), 32'h1);
    OP_TAKE = 1'b1;
    tick();
    OP_TAKE = 1'b0;
    #1;
    check("resume_pc",   32'(OP_PC), 32'h104);
    check("resume_word", OP_WORD,    32'hB3B2B1B0);

    // Address wrap at the top of the space.
    JUMP = 1'b1; JUMP_ADDR = 17'h1FFFC;
    tick();
    JUMP = 1'b0;
    tick(4);
    check("wrap_valid", 32'(OP_VALID), 32'h1);
    check("wrap_pc",    32'(OP_PC),    32'h1FFFC);
    check("wrap_word",  OP_WORD,       32'hF4F3F2F1);
    check("wrap_addr",  32'(MEM_ADDR), 32'h0);
    OP_TAKE = 1'b1;
    tick();
    OP_TAKE = 1'b0;
    #1;
    check("wrap_bubble", 32'(OP_VALID), 32'h0);
    tick(3);
    check("wrap_next_pc",   32'(OP_PC), 32'h0);
    check("wrap_next_word", OP_WORD,    32'h44332211);

    // Take on the same cycle a word completes: output refills directly.
    tick(3);
    OP_TAKE = 1'b1;
    tick();
    OP_TAKE = 1'b0;
    #1;
    check("tc_valid", 32'(OP_VALID), 32'h1);
    check("tc_pc",    32'(OP_PC),    32'h4);
    check("tc_word",  OP_WORD,       32'h88776655);

    // Reset mid-word at idx=2: asynchronous clear, restart at RESET_PC.
    tick(2);
    check("prerst_addr", 32'(MEM_ADDR), 32'hA);
    N_RST = 1'b0;
    #1;
    check("arst_valid", 32'(OP_VALID), 32'h0);
    check("arst_noe",   32'(MEM_N_OE), 32'h1);
    check("arst_addr",  32'(MEM_ADDR), 32'h0);
    tick();
    N_RST = 1'b1;
    #1;
    check("rel_noe",  32'(MEM_N_OE), 32'h0);
    check("rel_addr", 32'(MEM_ADDR), 32'h0);
    tick(4);
    check("rel_valid", 32'(OP_VALID), 32'h1);
    check("rel_pc",    32'(OP_PC),    32'h0);
    check("rel_word",  OP_WORD,       32'h44332211);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
